// File: rtl/cache_lru_pkg.sv
// Shared LRU types and helpers: op encoding, age-field width and the per-way
// packing rule used by lru_state_update and lru_age_update.
package cache_lru_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_TOUCH = 2'b01,
    OP_INVAL = 2'b10,
    OP_RSVD  = 2'b11
  } lru_op_e;

  function automatic int unsigned way_w(input int unsigned assoc);
    return $clog2(assoc);
  endfunction

  // Way i owns bits [slice_lo(i, W) +: W] of a packed age vector.
  function automatic int unsigned slice_lo(input int unsigned way, input int unsigned w);
    return way * w;
  endfunction

endpackage

// File: rtl/lru_age_update.sv
// Combinational age-vector update for one set: READ/TOUCH/INVAL, plus a
// permutation check on the result when LRU_CHECK_EN is defined.
module lru_age_update
  import cache_lru_pkg::*;
#(
  parameter  int unsigned ASSOC = 8,
  localparam int unsigned W     = way_w(ASSOC)
) (
  input  logic [W*ASSOC-1:0] i_old_bits,
  input  lru_op_e            i_op,
  input  logic [W-1:0]       i_way,
  output logic [W*ASSOC-1:0] o_new_bits
`ifdef LRU_CHECK_EN
  ,
  output logic               o_perm_err
`endif
);

  logic [W-1:0] w_cur;
  logic [W-1:0] w_age;

  always_comb begin
    o_new_bits = i_old_bits;
    w_age      = '0;
    w_cur      = i_old_bits[slice_lo(i_way, W) +: W];
    for (int unsigned i = 0; i < ASSOC; i++) begin
      w_age = i_old_bits[slice_lo(i, W) +: W];
      unique case (i_op)
        OP_TOUCH: begin
          if (W'(i) == i_way)   o_new_bits[slice_lo(i, W) +: W] = W'(ASSOC - 1);
          else if (w_age > w_cur) o_new_bits[slice_lo(i, W) +: W] = w_age - W'(1);
        end
        OP_INVAL: begin
          if (W'(i) == i_way)   o_new_bits[slice_lo(i, W) +: W] = '0;
          else if (w_age < w_cur) o_new_bits[slice_lo(i, W) +: W] = w_age + W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef LRU_CHECK_EN
  logic [ASSOC-1:0] w_seen;

  // ASSOC is 2**W, so every W-bit age indexes w_seen directly.
  always_comb begin
    w_seen = '0;
    for (int unsigned i = 0; i < ASSOC; i++) begin
      w_seen[o_new_bits[slice_lo(i, W) +: W]] = 1'b1;
    end
  end

  assign o_perm_err = (w_seen != '1);
`endif

endmodule

// File: rtl/lru_state_update.sv
// Per-set LRU age store with valid/ready request/response handshake.
// Optional sticky consistency checker enabled by LRU_CHECK_EN.
module lru_state_update
  import cache_lru_pkg::*;
#(
  parameter  int unsigned ASSOC = 8,
  parameter  int unsigned SETS  = 16,
  localparam int unsigned W     = way_w(ASSOC),
  localparam int unsigned SW    = $clog2(SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [SW-1:0]       req_set,
  input  logic [W-1:0]        req_way,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [SW-1:0]       resp_set,
  output logic [W*ASSOC-1:0]  resp_lru_bits,
  output logic                lru_err
);

  logic [W*ASSOC-1:0] r_ages [SETS];
  logic [W*ASSOC-1:0] w_new_bits;
  lru_op_e            w_op;
  logic               w_accept;

  assign w_op      = lru_op_e'(req_op);
  assign req_ready = !resp_valid || resp_ready;
  assign w_accept  = req_valid && req_ready;

`ifdef LRU_CHECK_EN
  logic w_perm_err;
  logic r_lru_err;
`endif

  lru_age_update #(
    .ASSOC (ASSOC)
  ) u_age_update (
    .i_old_bits (r_ages[req_set]),
    .i_op       (w_op),
    .i_way      (req_way),
    .o_new_bits (w_new_bits)
`ifdef LRU_CHECK_EN
    ,
    .o_perm_err (w_perm_err)
`endif
  );

  // The set is written on the accept edge, so a following request to the
  // same set already sees the update without forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned i = 0; i < ASSOC; i++) begin
          r_ages[s][slice_lo(i, W) +: W] <= W'(i);
        end
      end
      resp_valid    <= 1'b0;
      resp_set      <= '0;
      resp_lru_bits <= '0;
    end else if (w_accept) begin
      r_ages[req_set] <= w_new_bits;
      resp_valid      <= 1'b1;
      resp_set        <= req_set;
      resp_lru_bits   <= w_new_bits;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef LRU_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lru_err <= 1'b0;
    end else if (w_accept) begin
      if (w_op == OP_RSVD ||
          ((w_op == OP_TOUCH || w_op == OP_INVAL) && w_perm_err)) begin
        r_lru_err <= 1'b1;
      end
    end
  end

  assign lru_err = r_lru_err;
`else
  assign lru_err = 1'b0;
`endif

endmodule

// File: tb/tb_lru_state_update.sv
// Directed self-checking bench for lru_state_update (ASSOC=8, SETS=16).
// Expected lru_err depends on whether LRU_CHECK_EN is defined.
module tb_lru_state_update;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_set;
  logic [2:0]  req_way;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  resp_set;
  logic [23:0] resp_lru_bits;
  logic        lru_err;

  int checks = 0;
  int errors = 0;

`ifdef LRU_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  lru_state_update #(
    .ASSOC (8),
    .SETS  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_set       (req_set),
    .req_way       (req_way),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_set      (resp_set),
    .resp_lru_bits (resp_lru_bits),
    .lru_err       (lru_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [23:0] vec(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7);
    logic [23:0] r;
    r = {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    return r;
  endfunction

  // Recency-list model: order ways by age, move the touched way to the MRU end.
  function automatic logic [23:0] m_touch(input logic [23:0] v, input int w);
    int ord [8];
    int tmp [8];
    int n;
    logic [23:0] r;
    for (int i = 0; i < 8; i++) ord[int'(v[i*3 +: 3])] = i;
    n = 0;
    for (int a = 0; a < 8; a++) begin
      if (ord[a] != w) begin
        tmp[n] = ord[a];
        n++;
      end
    end
    tmp[7] = w;
    r = '0;
    for (int a = 0; a < 8; a++) r[tmp[a]*3 +: 3] = 3'(a);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input int s, input logic [23:0] bits);
    chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".set"}, 32'(resp_set), 32'(s));
    chk({tag, ".bits"}, 32'(resp_lru_bits), 32'(bits));
  endtask

  task automatic issue(input logic [1:0] op, input int s, input int w);
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = op;
    req_set    = 4'(s);
    req_way    = 3'(w);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  logic [23:0] ident;
  logic [23:0] cur [2];

  initial begin
    ident      = vec(0, 1, 2, 3, 4, 5, 6, 7);
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_set    = '0;
    req_way    = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_set", 32'(resp_set), 32'd0);
    chk("rst.bits", 32'(resp_lru_bits), 32'd0);
    chk("rst.lru_err", 32'(lru_err), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    issue(2'b00, 3, 0);  chk_resp("read3", 3, ident);
    issue(2'b00, 4, 5);  chk_resp("read4", 4, ident);
    issue(2'b00, 15, 0); chk_resp("read15", 15, ident);

    issue(2'b01, 3, 2);  chk_resp("touch3w2", 3, vec(0, 1, 7, 2, 3, 4, 5, 6));
    issue(2'b10, 3, 2);  chk_resp("inval3w2", 3, vec(1, 2, 0, 3, 4, 5, 6, 7));
    issue(2'b01, 3, 7);  chk_resp("touch_mru", 3, vec(1, 2, 0, 3, 4, 5, 6, 7));
    issue(2'b10, 3, 2);  chk_resp("inval_lru", 3, vec(1, 2, 0, 3, 4, 5, 6, 7));
    issue(2'b01, 5, 0);  chk_resp("touch5w0", 5, vec(7, 0, 1, 2, 3, 4, 5, 6));
    issue(2'b10, 5, 7);  chk_resp("inval5w7", 5, vec(7, 1, 2, 3, 4, 5, 6, 0));
    issue(2'b00, 4, 0);  chk_resp("read4b", 4, ident);

    // Backpressure with a TOUCH waiting behind the held READ set-4 response.
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_op     = 2'b01;
    req_set    = 4'd3;
    req_way    = 3'd1;
    #1;
    chk("bp.req_ready0", 32'(req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("bp.req_ready", 32'(req_ready), 32'd0);
      chk_resp("bp.hold", 4, ident);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk_resp("bp.accept", 3, vec(1, 7, 0, 2, 3, 4, 5, 6));
    @(posedge clk);
    #1;
    chk("bp.single", 32'(resp_valid), 32'd0);
    issue(2'b00, 3, 0);  chk_resp("bp.readback", 3, vec(1, 7, 0, 2, 3, 4, 5, 6));

    // Streaming TOUCH alternating between sets 0 and 1, one per cycle.
    cur[0] = ident;
    cur[1] = ident;
    for (int k = 0; k < 16; k++) begin
      cur[k % 2] = m_touch(cur[k % 2], (k * 3 + 1) % 8);
      issue(2'b01, k % 2, (k * 3 + 1) % 8);
      chk_resp("stream", k % 2, cur[k % 2]);
    end
    chk("stream.lru_err", 32'(lru_err), 32'd0);

    // Reserved op behaves as READ and trips the checker when enabled.
    issue(2'b11, 2, 5);  chk_resp("rsvd", 2, ident);
    chk("rsvd.lru_err", 32'(lru_err), 32'(EXP_ERR));
    issue(2'b00, 2, 0);  chk_resp("rsvd.after", 2, ident);
    chk("rsvd.sticky", 32'(lru_err), 32'(EXP_ERR));

    // Asynchronous reset in the middle of a stream.
    issue(2'b01, 6, 0);  chk_resp("pre_rst", 6, vec(7, 0, 1, 2, 3, 4, 5, 6));
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_set   = 4'd5;
    req_way   = 3'd3;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst.resp_set", 32'(resp_set), 32'd0);
    chk("mid_rst.bits", 32'(resp_lru_bits), 32'd0);
    chk("mid_rst.lru_err", 32'(lru_err), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst.hold_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b0;
    issue(2'b00, 6, 0);  chk_resp("post_rst6", 6, ident);
    issue(2'b00, 5, 0);  chk_resp("post_rst5", 5, ident);
    issue(2'b00, 3, 0);  chk_resp("post_rst3", 3, ident);
    chk("post_rst.lru_err", 32'(lru_err), 32'd0);

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lru_state_update.md
# lru_state_update

Per-set LRU age store and update engine for the set-associative cache model. It holds one packed age vector per set in the format that the victim selector (`eviction_LRU`) consumes. It accepts read, touch and invalidate requests through a valid/ready handshake, and returns the addressed set's age vector one cycle later. It sits directly upstream of the eviction selector: on a miss, the controller issues READ, feeds the returned vector to the selector, then issues TOUCH on the chosen victim at fill time.

## Interface
Parameters:
- `ASSOC`, default 8: ways per set; power of two, 2..16.
- `SETS`, default 16: sets stored; power of two.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid`.
- `req_op`  in  2  operation: 00 READ, 01 TOUCH, 10 INVAL, 11 reserved.
- `req_set`  in  $clog2(SETS)  set index.
- `req_way`  in  $clog2(ASSOC)  target way; ignored for READ.
- `resp_valid`  out  1  response held.
- `resp_ready`  in  1  downstream accepts the response.
- `resp_set`  out  $clog2(SETS)  echoed set index.
- `resp_lru_bits`  out  $clog2(ASSOC)*ASSOC  post-operation age vector; way i occupies bits [i*W +: W], where W = $clog2(ASSOC).
- `lru_err`  out  1  sticky consistency error (see Configuration).

## Operation
- Age encoding: each way has a W-bit counter. ASSOC-1 means MRU and 0 means LRU. Within a set, the counters always form a permutation of 0..ASSOC-1.
- Reset: set s, way i counter = i for every set. `resp_valid`=0, `resp_set`=0, `resp_lru_bits`=0, `lru_err`=0.
- Reset asserted mid-transaction discards any held response and reinitialises all sets; no partial update survives.
- READ: no state change. The response carries the current vector.
- TOUCH way w with counter c: every way with counter > c decrements by 1; way w becomes ASSOC-1. If c is already ASSOC-1, the vector is unchanged.
- INVAL way w with counter c: every way with counter < c increments by 1; way w becomes 0. If c is already 0, the vector is unchanged.
- Reserved op 11 behaves as READ.
- All arithmetic is W-bit unsigned. The compare rules above guarantee no wrap; any wrap is a bug.
- Handshake: `req_ready` = !`resp_valid` || `resp_ready`.
  - A request is accepted when `req_valid` && `req_ready`.
  - `resp_*` hold stable while `resp_valid` && !`resp_ready`.

## Timing
- Accept at edge N:
  - the set's new vector is written at edge N;
  - `resp_valid`=1 with the post-operation vector is visible after edge N (latency 1).
- Back-to-back requests to the same set see the previous update; there is no forwarding hazard, because the write completes at the accept edge.
- Full throughput of 1 request/cycle when `resp_ready` is held high.
- If `resp_ready` is low while `resp_valid` is high, `req_ready` deasserts combinationally and the request waits. No state changes until the request is accepted.
- Response drained and new request accepted on the same edge: `resp_valid` stays 1 and carries the new data.

## Configuration
- `LRU_CHECK_EN` defined:
  - each accepted TOUCH/INVAL result and each reserved op is checked;
  - if the post-operation vector is not a permutation of 0..ASSOC-1, or `req_op`==11, `lru_err` sets one cycle after accept and stays set until `rst`.
- Undefined: no checker logic is compiled in and `lru_err` is tied 0.

## Structure
- Shared package `cache_lru_pkg`:
  - op enum `lru_op_e` (READ, TOUCH, INVAL, RSVD);
  - function `way_w(assoc)` returning $clog2;
  - the packing rule, expressed as a slice helper.
- Sub-module `lru_age_update`: purely combinational. Inputs are the old vector, op and way; outputs are the new vector and the permutation-error flag.
- The top contains the age array, the handshake register and the check logic.

## Test plan
- Reset, ASSOC=8: READ set 3 → `resp_lru_bits` ways0..7 = 0,1,2,3,4,5,6,7; other sets are identical.
- TOUCH set 3 way 2 → ways0..7 = 0,1,7,2,3,4,5,6. Then INVAL set 3 way 2 → 1,2,0,3,4,5,6,7.
- TOUCH of the current MRU way, and INVAL of the current LRU way → vector unchanged; set 4 is untouched throughout.
- Backpressure: hold `resp_ready`=0 for 3 cycles with `req_valid`=1. Expect `req_ready`=0, the response stable, and no state change. Release and check single acceptance.
- Streaming 16 alternating TOUCH ops to sets 0/1 with `resp_ready`=1 → one response per cycle with correct chained vectors.
- `LRU_CHECK_EN`: issue op 11 → `lru_err`=1 next cycle and sticky. Assert `rst` mid-stream → all outputs return to reset values and all sets return to 0..7.
